l1_l2_arbiter: RTL and testbench
================================

Name: l1_l2_arbiter

Overview:
- Two-to-one line-request arbiter between the L1 instruction cache, the L1 data cache, and the shared L2 cache.
- It captures one L1 line request, presents it to the L2 controller's CPU-side port as a stable read or write, and routes the L2 response back to the requester.
- Round-robin priority prevents starvation. Saturating grant counters support performance measurement.

Parameters:
- ADDR_WIDTH, 32, line address width.
- LINE_WIDTH, 256, cache line width in bits.
- CNT_WIDTH, 32, width of each grant counter.
- D_FIRST, 1, which side wins the first tie after reset (1 = D-cache, 0 = I-cache).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- i_read  in  1  I-cache line read request, held until i_resp.
- i_address  in  ADDR_WIDTH  I-cache line address.
- i_rdata  out  LINE_WIDTH  read line to the I-cache.
- i_resp  out  1  one-cycle completion pulse to the I-cache.
- d_read  in  1  D-cache line read request.
- d_write  in  1  D-cache line write (writeback) request.
- d_address  in  ADDR_WIDTH  D-cache line address.
- d_wdata  in  LINE_WIDTH  D-cache writeback line.
- d_rdata  out  LINE_WIDTH  read line to the D-cache.
- d_resp  out  1  one-cycle completion pulse to the D-cache.
- l2_read  out  1  read request to the L2.
- l2_write  out  1  write request to the L2.
- l2_address  out  ADDR_WIDTH  latched request address.
- l2_wdata  out  LINE_WIDTH  latched write line.
- l2_rdata  in  LINE_WIDTH  L2 read data, valid with l2_resp.
- l2_resp  in  1  L2 completion pulse.
- perf_i_grants  out  CNT_WIDTH  count of I-side grants, saturating.
- perf_d_grants  out  CNT_WIDTH  count of D-side grants, saturating.

Behaviour:
- States: IDLE, BUSY_I, BUSY_D, RELEASE.
- Reset (rst_n low, any time, including mid-transaction):
  - state goes to IDLE; latched address, wdata and op are cleared.
  - Priority pointer is set to D_FIRST; both counters go to 0.
  - l2_read, l2_write, i_resp and d_resp are 0.
  - An in-flight L2 transaction is abandoned; a late l2_resp arriving in IDLE is ignored.
- IDLE: evaluates requests every cycle.
  - Only i_read high → grant I.
  - Only d_read or d_write high → grant D.
  - Both sides requesting → grant the side the pointer selects, then point the pointer at the other side.
  - A single-side grant also points the pointer away from the granted side.
  - On grant, latch address, op and (for a D write) d_wdata. Go to BUSY_I or BUSY_D and increment that side's counter. A counter at all-ones holds.
- Request priority within D: if d_read and d_write are both high, the write wins and l2_read stays 0.
- BUSY_x drive:
  - l2_read or l2_write from the latched op, exactly one high.
  - l2_address and l2_wdata from the latches, stable for the whole transaction regardless of L1 input changes.
- BUSY_x exit: on l2_resp, pulse x_resp in the same cycle (combinational from l2_resp and state) and go to RELEASE. The non-granted side's resp stays 0.
- RELEASE: l2_read, l2_write and both resps are 0 for exactly one cycle, then go to IDLE.
  - This gives the L1 a cycle to deassert its request.
  - It matches the L2 controller's return to its check state.
- Read data: i_rdata and d_rdata both continuously equal l2_rdata. Only the resp pulse qualifies them.
- Latency:
  - A request first high at IDLE edge N gives l2_read/l2_write high from cycle N+1.
  - The next grant is possible two cycles after l2_resp (RELEASE, then IDLE decision).
- l2_read and l2_write are 0 in IDLE and RELEASE. No pass-through combinational path exists from L1 request inputs to L2 outputs.
- An L1 request dropped while its side is BUSY has no effect; the transaction completes and the resp still pulses.

Test Plan:
- Lone I read: i_read=1, i_address=0x0000_1000 → l2_read=1, l2_address=0x1000 next cycle. l2_resp with l2_rdata=0xA5…A5 → i_resp=1 for 1 cycle, i_rdata=0xA5…A5, d_resp=0, perf_i_grants=1.
- Tie after reset (D_FIRST=1): i_read and d_read high in the same cycle → D served first, then RELEASE, IDLE, I served. A second simultaneous tie is granted to D, because the pointer moves away from the last grant (I).
- D writeback: d_write=1, d_address=0x2000, d_wdata=0x1234… → l2_write=1, l2_wdata stable. Change d_wdata to 0 mid-transaction → l2_wdata is unchanged until d_resp.
- Back-to-back saturation and starvation: both sides request continuously for 10 transactions → grants alternate D, I, D, I…, and each grant is separated by exactly one RELEASE cycle plus one IDLE cycle.
- Reset mid-transaction: rst_n low while BUSY_D with l2_write=1 → l2_write=0 asynchronously and counters are 0. A subsequent l2_resp with no request gives no resp pulse.
- Counter saturation (CNT_WIDTH=4): 17 I grants → perf_i_grants=15.

Source files
------------

// File: rtl/l1_l2_arbiter_if.sv
// L1 I/D request-response signals and the L2 CPU-side port, as seen by the arbiter.
// slave: arbiter view; master: environment view (both L1 caches plus the L2 controller).
interface l1_l2_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 256
);
   logic                  i_read;
   logic [ADDR_WIDTH-1:0] i_address;
   logic [LINE_WIDTH-1:0] i_rdata;
   logic                  i_resp;

   logic                  d_read;
   logic                  d_write;
   logic [ADDR_WIDTH-1:0] d_address;
   logic [LINE_WIDTH-1:0] d_wdata;
   logic [LINE_WIDTH-1:0] d_rdata;
   logic                  d_resp;

   logic                  l2_read;
   logic                  l2_write;
   logic [ADDR_WIDTH-1:0] l2_address;
   logic [LINE_WIDTH-1:0] l2_wdata;
   logic [LINE_WIDTH-1:0] l2_rdata;
   logic                  l2_resp;

   modport slave (
      input  i_read, i_address, d_read, d_write, d_address, d_wdata, l2_rdata, l2_resp,
      output i_rdata, i_resp, d_rdata, d_resp, l2_read, l2_write, l2_address, l2_wdata
   );

   modport master (
      output i_read, i_address, d_read, d_write, d_address, d_wdata, l2_rdata, l2_resp,
      input  i_rdata, i_resp, d_rdata, d_resp, l2_read, l2_write, l2_address, l2_wdata
   );
endinterface

// File: rtl/l1_l2_arbiter.sv
// Round-robin 2:1 arbiter of L1 I/D line requests onto the L2 port, with saturating grant counters.
// L2 request is registered one cycle after grant; L1 holds its request until resp; next grant two cycles after l2_resp.
module l1_l2_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 256,
   parameter int CNT_WIDTH  = 32,
   parameter bit D_FIRST    = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   l1_l2_arbiter_if.slave       bus,
   output logic [CNT_WIDTH-1:0] perf_i_grants,
   output logic [CNT_WIDTH-1:0] perf_d_grants
);
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_I  = 2'd1,
      BUSY_D  = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic                  r_ptr_d;
   logic                  r_op_write;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [LINE_WIDTH-1:0] r_wdata;
   logic [CNT_WIDTH-1:0]  r_cnt_i;
   logic [CNT_WIDTH-1:0]  r_cnt_d;

   logic w_d_req;
   logic w_grant_i;
   logic w_grant_d;
   logic w_busy;

   assign w_d_req = bus.d_read | bus.d_write;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_grant_i    = 1'b0;
      w_grant_d    = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.i_read && w_d_req) begin
               w_grant_d = r_ptr_d;
               w_grant_i = !r_ptr_d;
            end else begin
               w_grant_i = bus.i_read;
               w_grant_d = w_d_req;
            end
            if (w_grant_i) begin
               w_next_state = BUSY_I;
            end else if (w_grant_d) begin
               w_next_state = BUSY_D;
            end
         end
         BUSY_I, BUSY_D: begin
            if (bus.l2_resp) begin
               w_next_state = RELEASE;
            end
         end
         RELEASE: begin
            w_next_state = IDLE;
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // Latches are written only at the grant edge, so L2 sees a request that ignores later L1 input changes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr_d    <= D_FIRST;
         r_op_write <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_cnt_i    <= '0;
         r_cnt_d    <= '0;
      end else begin
         if (w_grant_i) begin
            r_ptr_d    <= 1'b1;
            r_op_write <= 1'b0;
            r_addr     <= bus.i_address;
            if (r_cnt_i != '1) begin
               r_cnt_i <= r_cnt_i + CNT_WIDTH'(1);
            end
         end
         if (w_grant_d) begin
            r_ptr_d    <= 1'b0;
            r_op_write <= bus.d_write;
            r_addr     <= bus.d_address;
            if (bus.d_write) begin
               r_wdata <= bus.d_wdata;
            end
            if (r_cnt_d != '1) begin
               r_cnt_d <= r_cnt_d + CNT_WIDTH'(1);
            end
         end
      end
   end

   assign w_busy         = (r_state == BUSY_I) || (r_state == BUSY_D);
   assign bus.l2_read    = w_busy && !r_op_write;
   assign bus.l2_write   = w_busy && r_op_write;
   assign bus.l2_address = r_addr;
   assign bus.l2_wdata   = r_wdata;

   // Response pulses are combinational so the L1 sees completion in the same cycle as l2_resp.
   assign bus.i_resp  = (r_state == BUSY_I) && bus.l2_resp;
   assign bus.d_resp  = (r_state == BUSY_D) && bus.l2_resp;
   assign bus.i_rdata = bus.l2_rdata;
   assign bus.d_rdata = bus.l2_rdata;

   assign perf_i_grants = r_cnt_i;
   assign perf_d_grants = r_cnt_d;
endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Randomized and directed bench for l1_l2_arbiter against a transaction-level reference model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_l1_l2_arbiter;
   localparam int AW      = 32;
   localparam int LW      = 256;
   localparam int CW      = 4;
   localparam int CNT_MAX = (1 << CW) - 1;
   localparam int SIDE_I  = 1;
   localparam int SIDE_D  = 2;

   typedef logic [LW-1:0] line_t;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic [CW-1:0] perf_i;
   logic [CW-1:0] perf_d;

   always #5 clk = ~clk;

   l1_l2_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

   l1_l2_arbiter #(
      .ADDR_WIDTH(AW),
      .LINE_WIDTH(LW),
      .CNT_WIDTH (CW),
      .D_FIRST   (1'b1)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .perf_i_grants(perf_i),
      .perf_d_grants(perf_d)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check_val(input string tag, input line_t obs, input line_t exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: which side owns the L2, whether the one-cycle release gap is pending, tie pointer, latched request.
   int          m_owner;
   bit          m_release;
   bit          m_next_d;
   bit          m_wr;
   logic [AW-1:0] m_addr;
   line_t       m_wdata;
   int          m_cnt_i;
   int          m_cnt_d;
   int          cyc;
   int          glog[$];
   int          gcyc[$];
   int          rlog[$];

   // Stimulus configuration and L1/L2 behaviour state.
   int            p_i, p_d, dop_mode, fix_lat, lat;
   bit            rand_data, stray, allow_drop, force_resp;
   bit            i_up, d_up, d_rd, d_wr, got_i_resp, got_d_resp, drv_resp;
   logic [AW-1:0] fix_i_addr, fix_d_addr;
   line_t         fix_wdata, fix_rdata, drv_rdata;

   function automatic line_t rand_line();
      line_t r;
      for (int k = 0; k < LW / 32; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic model_reset();
      m_owner   = 0;
      m_release = 1'b0;
      m_next_d  = 1'b1;
      m_wr      = 1'b0;
      m_addr    = '0;
      m_wdata   = '0;
      m_cnt_i   = 0;
      m_cnt_d   = 0;
      glog.delete();
      gcyc.delete();
      rlog.delete();
   endtask

   // Apply the rising edge that just passed, using the inputs that were stable across it.
   task automatic model_advance();
      bit iq;
      bit dq;
      int pick;
      if (!rst_n) begin
         model_reset();
         return;
      end
      if (m_owner != 0) begin
         if (drv_resp) begin
            m_owner   = 0;
            m_release = 1'b1;
            rlog.push_back(cyc - 1);
         end
      end else if (m_release) begin
         m_release = 1'b0;
      end else begin
         iq   = bus.i_read;
         dq   = bus.d_read | bus.d_write;
         pick = 0;
         if (iq && dq)  pick = m_next_d ? SIDE_D : SIDE_I;
         else if (iq)   pick = SIDE_I;
         else if (dq)   pick = SIDE_D;
         if (pick == SIDE_I) begin
            m_wr   = 1'b0;
            m_addr = bus.i_address;
            if (m_cnt_i < CNT_MAX) m_cnt_i++;
         end else if (pick == SIDE_D) begin
            m_wr   = bus.d_write;
            m_addr = bus.d_address;
            if (m_wr) m_wdata = bus.d_wdata;
            if (m_cnt_d < CNT_MAX) m_cnt_d++;
         end
         if (pick != 0) begin
            m_owner  = pick;
            m_next_d = (pick == SIDE_I);
            glog.push_back(pick);
            gcyc.push_back(cyc);
         end
      end
   endtask

   task automatic check_regs();
      check_val("l2_read", line_t'(bus.l2_read), line_t'((m_owner != 0) && !m_wr));
      check_val("l2_write", line_t'(bus.l2_write), line_t'((m_owner != 0) && m_wr));
      if (m_owner != 0) check_val("l2_address", line_t'(bus.l2_address), line_t'(m_addr));
      if (m_owner != 0 && m_wr) check_val("l2_wdata", bus.l2_wdata, m_wdata);
      check_val("perf_i", line_t'(perf_i), line_t'(m_cnt_i));
      check_val("perf_d", line_t'(perf_d), line_t'(m_cnt_d));
   endtask

   task automatic drive_inputs();
      int r;
      if (got_i_resp) i_up = 1'b0;
      else if (!i_up) begin
         if ($urandom_range(0, 99) < p_i) i_up = 1'b1;
      end else if (allow_drop && $urandom_range(0, 15) == 0) i_up = 1'b0;

      if (got_d_resp) d_up = 1'b0;
      else if (!d_up) begin
         if ($urandom_range(0, 99) < p_d) begin
            d_up = 1'b1;
            r = (dop_mode == 1) ? 0 : (dop_mode == 2) ? 1 : $urandom_range(0, 2);
            d_rd = (r != 1);
            d_wr = (r != 0);
         end
      end else if (allow_drop && $urandom_range(0, 15) == 0) d_up = 1'b0;

      bus.i_read    = i_up;
      bus.d_read    = d_up && d_rd;
      bus.d_write   = d_up && d_wr;
      bus.i_address = rand_data ? AW'($urandom) : fix_i_addr;
      bus.d_address = rand_data ? AW'($urandom) : fix_d_addr;
      bus.d_wdata   = rand_data ? rand_line() : fix_wdata;

      drv_rdata = rand_data ? rand_line() : fix_rdata;
      drv_resp  = 1'b0;
      if (force_resp) drv_resp = 1'b1;
      else if (bus.l2_read || bus.l2_write) begin
         if (lat == 0) begin
            drv_resp = 1'b1;
            lat      = (fix_lat >= 0) ? fix_lat : $urandom_range(0, 3);
         end else lat--;
      end else if (stray && $urandom_range(0, 7) == 0) drv_resp = 1'b1;
      bus.l2_rdata = drv_rdata;
      bus.l2_resp  = drv_resp;
   endtask

   task automatic check_comb();
      check_val("i_resp", line_t'(bus.i_resp), line_t'((m_owner == SIDE_I) && drv_resp));
      check_val("d_resp", line_t'(bus.d_resp), line_t'((m_owner == SIDE_D) && drv_resp));
      check_val("i_rdata", bus.i_rdata, drv_rdata);
      check_val("d_rdata", bus.d_rdata, drv_rdata);
      got_i_resp = bus.i_resp;
      got_d_resp = bus.d_resp;
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
      model_advance();
      check_regs();
      drive_inputs();
      #1;
      check_comb();
   endtask

   task automatic quiet();
      p_i = 0; p_d = 0; dop_mode = 0; fix_lat = -1;
      rand_data = 1'b1; stray = 1'b0; allow_drop = 1'b0; force_resp = 1'b0;
   endtask

   task automatic run_grants(input int n, input int budget);
      int k = 0;
      while (glog.size() < n && k < budget) begin
         step();
         k++;
      end
      check_val("grant_count", line_t'(glog.size()), line_t'(n));
   endtask

   task automatic run_idle(input int budget);
      int k = 0;
      while ((i_up || d_up || m_owner != 0 || m_release) && k < budget) begin
         step();
         k++;
      end
      check_val("drain", line_t'(i_up || d_up || m_owner != 0), line_t'(0));
   endtask

   task automatic apply_reset();
      quiet();
      rst_n = 1'b0;
      i_up = 1'b0; d_up = 1'b0; got_i_resp = 1'b0; got_d_resp = 1'b0; lat = 0;
      repeat (2) step();
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      line_t a5_line;
      line_t wb_line;
      int    s;
      int    k;
      a5_line = {32{8'hA5}};
      wb_line = {8{32'h1234_5678}};
      quiet();
      bus.i_read = 1'b0; bus.i_address = '0; bus.d_read = 1'b0; bus.d_write = 1'b0;
      bus.d_address = '0; bus.d_wdata = '0; bus.l2_rdata = '0; bus.l2_resp = 1'b0;
      drv_resp = 1'b0; drv_rdata = '0; i_up = 0; d_up = 0; d_rd = 0; d_wr = 0;
      got_i_resp = 0; got_d_resp = 0; lat = 0; cyc = 0;
      fix_i_addr = '0; fix_d_addr = '0; fix_wdata = '0; fix_rdata = '0;
      model_reset();

      apply_reset();
      check_val("reset_l2_read", line_t'(bus.l2_read), line_t'(0));
      check_val("reset_perf_i", line_t'(perf_i), line_t'(0));

      // Lone I read
      p_i = 100; rand_data = 1'b0; fix_i_addr = 32'h0000_1000; fix_rdata = a5_line;
      fix_lat = 2; lat = 2;
      run_grants(1, 20);
      check_val("lone_l2_read", line_t'(bus.l2_read), line_t'(1));
      check_val("lone_l2_addr", line_t'(bus.l2_address), line_t'(32'h1000));
      p_i = 0;
      k = 0;
      while (!got_i_resp && k < 20) begin step(); k++; end
      check_val("lone_i_resp_seen", line_t'(got_i_resp), line_t'(1));
      check_val("lone_i_rdata", bus.i_rdata, a5_line);
      check_val("lone_d_resp", line_t'(bus.d_resp), line_t'(0));
      check_val("lone_perf_i", line_t'(perf_i), line_t'(1));
      run_idle(20);

      // Simultaneous ties after reset: D, then I, then D again
      apply_reset();
      p_i = 100; p_d = 100; dop_mode = 1;
      run_grants(3, 80);
      p_i = 0; p_d = 0;
      run_idle(40);
      check_val("tie_first", line_t'(glog[0]), line_t'(SIDE_D));
      check_val("tie_second", line_t'(glog[1]), line_t'(SIDE_I));
      check_val("tie_third", line_t'(glog[2]), line_t'(SIDE_D));

      // D writeback with d_wdata changed mid-transaction
      p_d = 100; dop_mode = 2; rand_data = 1'b0; fix_d_addr = 32'h2000; fix_wdata = wb_line;
      fix_lat = 4; lat = 4;
      run_grants(glog.size() + 1, 20);
      check_val("wb_l2_write", line_t'(bus.l2_write), line_t'(1));
      check_val("wb_l2_addr", line_t'(bus.l2_address), line_t'(32'h2000));
      p_d = 0; fix_wdata = '0;
      k = 0;
      while (!got_d_resp && k < 20) begin
         step();
         check_val("wb_wdata_hold", bus.l2_wdata, wb_line);
         k++;
      end
      check_val("wb_d_resp_seen", line_t'(got_d_resp), line_t'(1));
      run_idle(20);

      // Continuous requests from both sides: strict alternation and a fixed gap
      quiet();
      s = glog.size();
      p_i = 100; p_d = 100;
      run_grants(s + 10, 200);
      p_i = 0; p_d = 0;
      run_idle(40);
      for (int j = s + 1; j < s + 10; j++) begin
         check_val("alternate", line_t'(glog[j]), line_t'(3 - glog[j-1]));
         check_val("grant_gap", line_t'(gcyc[j] - rlog[j-1]), line_t'(3));
      end

      // Randomized traffic with drops, stray L2 responses and changing inputs
      quiet();
      stray = 1'b1; allow_drop = 1'b1;
      for (int blk = 0; blk < 12; blk++) begin
         p_i = $urandom_range(10, 90);
         p_d = $urandom_range(10, 90);
         repeat (50) step();
      end
      quiet();
      run_idle(60);

      // Reset while a D write is in flight
      p_d = 100; dop_mode = 2; fix_lat = 6; lat = 6;
      run_grants(glog.size() + 1, 20);
      check_val("mid_l2_write_before", line_t'(bus.l2_write), line_t'(1));
      rst_n = 1'b0;
      #1;
      check_val("mid_l2_write_async", line_t'(bus.l2_write), line_t'(0));
      check_val("mid_l2_read_async", line_t'(bus.l2_read), line_t'(0));
      check_val("mid_perf_i", line_t'(perf_i), line_t'(0));
      check_val("mid_perf_d", line_t'(perf_d), line_t'(0));
      quiet();
      model_reset();
      i_up = 0; d_up = 0; got_i_resp = 0; got_d_resp = 0; lat = 0;
      repeat (2) step();
      rst_n = 1'b1;
      step();
      force_resp = 1'b1;
      step();
      force_resp = 1'b0;
      check_val("late_resp_ignored", line_t'(got_i_resp | got_d_resp), line_t'(0));
      repeat (2) step();

      // Counter saturation: 17 I grants into a 4-bit counter
      p_i = 100; fix_lat = 0; lat = 0;
      run_grants(17, 150);
      p_i = 0;
      run_idle(20);
      check_val("sat_perf_i", line_t'(perf_i), line_t'(15));
      check_val("sat_perf_d", line_t'(perf_d), line_t'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
